lsu_stack: RTL
==============

LSU_STACK -- requirements
Module: lsu_stack

Interface
REQ-001 SHALL have parameter STACK_BASE, default 8'hFF: highest stack address, the initial and empty stack pointer value.
REQ-002 SHALL have parameter STACK_LIMIT, default 8'hC0: lowest address a push may write.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: program-load phase flag, the same signal the data memory receives.
REQ-006 SHALL have port req, input, 1 bit: operation request, sampled only in IDLE.
REQ-007 SHALL have port op, input, 3 bits: 0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 COPY; 5-7 are illegal.
REQ-008 SHALL have port addr_a, input, 8 bits: LOAD/STORE address, or COPY source.
REQ-009 SHALL have port addr_b, input, 8 bits: COPY destination.
REQ-010 SHALL have port wdata, input, 8 bits: STORE/PUSH data.
REQ-011 SHALL have port len, input, 8 bits: COPY byte count; 0 means no transfer.
REQ-012 SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: valid with ack; 1 means the operation was rejected.
REQ-014 SHALL have port rdata, output, 8 bits: LOAD/POP result, held until the next ack.
REQ-015 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.
REQ-016 SHALL have port sp, output, 8 bits: current stack pointer, the next free slot.
REQ-017 SHALL have port empty, output, 1 bit: 1 when sp == STACK_BASE.
REQ-018 SHALL have port full, output, 1 bit: 1 when sp == STACK_LIMIT-1.
REQ-019 SHALL have port mem_addr, output, 8 bits: data memory address.
REQ-020 SHALL have port mem_wdata, output, 8 bits: data memory write data.
REQ-021 SHALL have port mem_wr_en, output, 1 bit: data memory write enable.
REQ-022 SHALL have port mem_rdata, input, 8 bits: combinational read data from the data memory.

Function
REQ-023 SHALL implement FSM states IDLE, EXEC, COPY_RD, COPY_WR and DONE.
REQ-024 SHALL, in IDLE with req=1 and start=0, register op, addr_a, addr_b, wdata and len, then go to EXEC; req in any other state SHALL be ignored.
REQ-025 SHALL, in EXEC for LOAD, drive mem_addr=addr_a and capture mem_rdata into rdata at the clock edge; go to DONE.
REQ-026 SHALL, in EXEC for STORE, drive mem_addr=addr_a, mem_wdata=wdata and mem_wr_en=1 for exactly one cycle; go to DONE.
REQ-027 SHALL, in EXEC for PUSH with full=0, write wdata at address sp for one cycle, then sp <= sp-1; go to DONE.
REQ-028 SHALL, in EXEC for POP with empty=0, read address sp+1 into rdata, then sp <= sp+1; go to DONE.
REQ-029 SHALL, in EXEC for COPY, go to DONE if len==0; otherwise clear the index counter i and go to COPY_RD.
REQ-030 SHALL, in COPY_RD, drive mem_addr=addr_a+i and capture mem_rdata into a byte buffer; go to COPY_WR.
REQ-031 SHALL, in COPY_WR, write the byte buffer to addr_b+i for one cycle with i <= i+1; return to COPY_RD if i+1 < len, else go to DONE.
REQ-032 SHALL compute all address sums modulo 256 (wrap 8'hFF to 8'h00) and copy forward only, with no overlap correction.
REQ-033 SHALL reject PUSH when full, POP when empty, and ops 5-7: no memory write, sp and rdata unchanged, err=1 with ack.
REQ-034 SHALL, in DONE, assert ack=1 for one cycle with err valid, then return to IDLE.
REQ-035 SHALL give LOAD/STORE/PUSH/POP a latency of ack 2 cycles after the accept edge, and COPY a latency of 2+2*len cycles.
REQ-036 SHALL hold mem_wr_en=0 in every state except an EXEC write and COPY_WR.
REQ-037 SHALL, when start=1 in any state, force state to IDLE and mem_wr_en to 0 with no ack, leaving sp and rdata unchanged.

Reset
REQ-038 SHALL, when rst_n=0 at a clock edge, set: state IDLE, sp=STACK_BASE, rdata=0, ack=0, err=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, i=0.
REQ-039 SHALL let reset take priority over start and over any in-flight operation, including a COPY; the aborted operation gives no ack.

Structure
REQ-040 SHALL place the op encoding enum, the FSM state enum and the STACK_BASE/STACK_LIMIT defaults in shared package lsu_pkg.
REQ-041 SHALL be a single module with no sub-modules; the bench SHALL connect it to the existing 256x8 data memory.

Verification
REQ-042 SHALL test STORE 8'h5A at 8'h10, then LOAD 8'h10 -> rdata=8'h5A, err=0, each ack 2 cycles after accept.
REQ-043 SHALL test PUSH 8'h11, PUSH 8'h22, POP, POP -> rdata 8'h22 then 8'h11, sp ending at 8'hFF, empty=1; a further POP -> err=1.
REQ-044 SHALL test 64 PUSHes -> full=1 and sp=8'hBF; a 65th PUSH -> err=1, mem[8'hBF] unchanged.
REQ-045 SHALL test COPY from 8'hFE to 8'h20 with len=4 -> mem[20..23]=mem[FE,FF,00,01], ack 10 cycles after accept; len=0 -> ack after 2 cycles, no write.
REQ-046 SHALL test start=1 mid-COPY -> IDLE next cycle, no further writes, no ack; rst_n=0 -> sp=8'hFF, busy=0.
REQ-047 SHALL test op=6 -> err=1, no write; req held during busy -> exactly one operation accepted.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store/stack unit: op encoding, FSM
// state encoding and the default stack window.
package lsu_pkg;

  localparam logic [7:0] LSU_STACK_BASE  = 8'hFF;
  localparam logic [7:0] LSU_STACK_LIMIT = 8'hC0;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_COPY  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_COPY_RD = 3'd2,
    ST_COPY_WR = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/lsu_stack.sv
// Load/store unit with a downward-growing hardware stack and a forward
// byte-copy engine, in front of a 256x8 data memory whose read data is
// combinational. Memory address, write data and write enable are
// registered, so the address of each access is set up one edge early.
module lsu_stack
  import lsu_pkg::*;
#(
  parameter logic [7:0] STACK_BASE  = LSU_STACK_BASE,
  parameter logic [7:0] STACK_LIMIT = LSU_STACK_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       req,
  input  logic [2:0] op,
  input  logic [7:0] addr_a,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata,
  input  logic [7:0] len,
  output logic       ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic [7:0] sp,
  output logic       empty,
  output logic       full,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_wr_en,
  input  logic [7:0] mem_rdata
);

  state_e     state;
  logic [2:0] cur_op;
  logic [7:0] cur_a;
  logic [7:0] cur_b;
  logic [7:0] cur_len;
  logic [7:0] idx;

  logic [7:0] accept_addr;
  logic       accept_wr;
  logic [7:0] next_idx;
  logic       more_copy;

  assign busy  = (state != ST_IDLE);
  assign empty = (sp == STACK_BASE);
  assign full  = (sp == (STACK_LIMIT - 8'd1));

  assign next_idx  = idx + 8'd1;
  assign more_copy = (next_idx < cur_len);

  // Decode the address and write strobe to present during EXEC for a new request.
  always_comb begin
    accept_addr = addr_a;
    accept_wr   = 1'b0;
    case (op)
      OP_LOAD: begin
        accept_addr = addr_a;
        accept_wr   = 1'b0;
      end
      OP_STORE: begin
        accept_addr = addr_a;
        accept_wr   = 1'b1;
      end
      OP_PUSH: begin
        accept_addr = sp;
        accept_wr   = !full;
      end
      OP_POP: begin
        accept_addr = sp + 8'd1;
        accept_wr   = 1'b0;
      end
      OP_COPY: begin
        accept_addr = addr_a;
        accept_wr   = 1'b0;
      end
      default: begin
        accept_addr = addr_a;
        accept_wr   = 1'b0;
      end
    endcase
  end

  // Main FSM: reset beats start, start beats any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sp        <= STACK_BASE;
      rdata     <= 8'h00;
      ack       <= 1'b0;
      err       <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      idx       <= 8'h00;
      cur_op    <= 3'd0;
      cur_a     <= 8'h00;
      cur_b     <= 8'h00;
      cur_len   <= 8'h00;
    end else if (start) begin
      state     <= ST_IDLE;
      mem_wr_en <= 1'b0;
      ack       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack       <= 1'b0;
          mem_wr_en <= 1'b0;
          if (req) begin
            cur_op    <= op;
            cur_a     <= addr_a;
            cur_b     <= addr_b;
            cur_len   <= len;
            // mem_wdata doubles as the latched STORE/PUSH operand.
            mem_wdata <= wdata;
            mem_addr  <= accept_addr;
            mem_wr_en <= accept_wr;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          mem_wr_en <= 1'b0;
          case (cur_op)
            OP_LOAD: begin
              rdata <= mem_rdata;
              err   <= 1'b0;
              ack   <= 1'b1;
              state <= ST_DONE;
            end
            OP_STORE: begin
              err   <= 1'b0;
              ack   <= 1'b1;
              state <= ST_DONE;
            end
            OP_PUSH: begin
              if (!full) begin
                sp  <= sp - 8'd1;
                err <= 1'b0;
              end else begin
                err <= 1'b1;
              end
              ack   <= 1'b1;
              state <= ST_DONE;
            end
            OP_POP: begin
              if (!empty) begin
                rdata <= mem_rdata;
                sp    <= sp + 8'd1;
                err   <= 1'b0;
              end else begin
                err <= 1'b1;
              end
              ack   <= 1'b1;
              state <= ST_DONE;
            end
            OP_COPY: begin
              err <= 1'b0;
              if (cur_len == 8'h00) begin
                ack   <= 1'b1;
                state <= ST_DONE;
              end else begin
                idx      <= 8'h00;
                mem_addr <= cur_a;
                state    <= ST_COPY_RD;
              end
            end
            default: begin
              err   <= 1'b1;
              ack   <= 1'b1;
              state <= ST_DONE;
            end
          endcase
        end
        ST_COPY_RD: begin
          // The write-data register is the copy byte buffer.
          mem_wdata <= mem_rdata;
          mem_addr  <= cur_b + idx;
          mem_wr_en <= 1'b1;
          state     <= ST_COPY_WR;
        end
        ST_COPY_WR: begin
          mem_wr_en <= 1'b0;
          idx       <= next_idx;
          if (more_copy) begin
            mem_addr <= cur_a + next_idx;
            state    <= ST_COPY_RD;
          end else begin
            err   <= 1'b0;
            ack   <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack       <= 1'b0;
          mem_wr_en <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          ack       <= 1'b0;
          mem_wr_en <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
